// File: rtl/fp_param_pkg.sv
// rtl/fp_param_pkg.sv - shared states, flag indices and encoding helpers for the parametrised FP units
package fp_param_pkg;

  typedef enum logic [3:0] {
    ST_GET_OPS,
    ST_UNPACK,
    ST_SPECIAL,
    ST_ALIGN,
    ST_ADD,
    ST_NORM_CARRY,
    ST_NORMALISE,
    ST_DENORM,
    ST_ROUND,
    ST_PACK,
    ST_PUT_Z
  } fp_state_t;

  localparam int FLAG_W        = 3;
  localparam int FLAG_INVALID  = 2;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_INEXACT  = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Encodings are built in 64 bits and truncated by the caller to its word width.
  function automatic logic [63:0] fp_inf(input int exp_w, input int man_w);
    logic [63:0] ones;
    ones = (64'd1 << exp_w) - 64'd1;
    return ones << man_w;
  endfunction

  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return fp_inf(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_addsub_param_if.sv
// rtl/fp_addsub_param_if.sv - stb/ack operand and result channels of the FP add/sub unit
interface fp_addsub_param_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  import fp_param_pkg::*;

  localparam int W = 1 + EXP_W + MAN_W;

  logic [W-1:0]      input_a;
  logic [W-1:0]      input_b;
  logic              input_op;
  logic              input_stb;
  logic              input_ack;
  logic [W-1:0]      output_z;
  logic [FLAG_W-1:0] output_flags;
  logic              output_z_stb;
  logic              output_z_ack;

  modport master (
    output input_a, input_b, input_op, input_stb, output_z_ack,
    input  input_ack, output_z, output_flags, output_z_stb
  );

  modport slave (
    input  input_a, input_b, input_op, input_stb, output_z_ack,
    output input_ack, output_z, output_flags, output_z_stb
  );

endinterface

// File: rtl/fp_unpack.sv
// rtl/fp_unpack.sv - combinational IEEE-754 field split with class and denormal detect
module fp_unpack
  import fp_param_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0]     word,
  output logic                     sign,
  output logic signed [EXP_W+1:0]  exp_unb,
  output logic [MAN_W-1:0]         frac,
  output logic                     is_zero,
  output logic                     is_denorm,
  output logic                     is_inf,
  output logic                     is_nan
);

  localparam int EW   = EXP_W + 2;
  localparam int BIAS = fp_bias(EXP_W);
  localparam logic signed [EW-1:0] E_MIN = EW'(1 - BIAS);

  logic [EXP_W-1:0] exp_field;
  logic             exp_zero;
  logic             exp_ones;
  logic             frac_zero;

  always_comb begin
    sign      = word[EXP_W+MAN_W];
    exp_field = word[EXP_W+MAN_W-1:MAN_W];
    frac      = word[MAN_W-1:0];
    exp_zero  = (exp_field == '0);
    exp_ones  = &exp_field;
    frac_zero = (frac == '0);
    is_zero   = exp_zero && frac_zero;
    is_denorm = exp_zero && !frac_zero;
    is_inf    = exp_ones && frac_zero;
    is_nan    = exp_ones && !frac_zero;
    // Denormals share the minimum normal exponent; only the hidden bit differs.
    if (exp_zero)
      exp_unb = E_MIN;
    else
      exp_unb = $signed({2'b00, exp_field}) - $signed(EW'(BIAS));
  end

endmodule

// File: rtl/fp_addsub_param.sv
// rtl/fp_addsub_param.sv - multi-cycle parametrised IEEE-754 add/subtract with RNE rounding and flags
module fp_addsub_param
  import fp_param_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic              clk,
  input logic              rst,
  fp_addsub_param_if.slave bus
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int EW   = EXP_W + 2;
  localparam int MW   = MAN_W + 4;
  localparam int SW   = MAN_W + 5;
  localparam int BIAS = fp_bias(EXP_W);

  localparam logic signed [EW-1:0] E_MIN         = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] E_MAX         = EW'(BIAS);
  localparam logic signed [EW:0]   ALIGN_LIM     = (EW+1)'(MAN_W + 3);
  localparam logic signed [EW:0]   ALIGN_LIM_NEG = (EW+1)'(-(MAN_W + 3));
  localparam logic [W-1:0]         QNAN          = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic [W-1:0]         INF           = W'(fp_inf(EXP_W, MAN_W));
  localparam logic [FLAG_W-1:0]    FL_INVALID    = FLAG_W'(1 << FLAG_INVALID);
  localparam logic [FLAG_W-1:0]    FL_OVF_INX    = FLAG_W'((1 << FLAG_OVERFLOW) | (1 << FLAG_INEXACT));
  localparam logic [FLAG_W-1:0]    FL_INEXACT    = FLAG_W'(1 << FLAG_INEXACT);

  fp_state_t state, state_nxt;

  logic [W-1:0]          a_q, b_q;
  logic                  op_q;
  logic                  a_s, b_s, z_s;
  logic signed [EW-1:0]  a_e, b_e, z_e;
  logic [MW-1:0]         a_m, b_m;
  logic [SW-1:0]         z_m;

  logic                  ua_sign, ub_sign;
  logic signed [EW-1:0]  ua_exp, ub_exp;
  logic [MAN_W-1:0]      ua_frac, ub_frac;
  logic                  ua_zero, ua_den, ua_inf, ua_nan;
  logic                  ub_zero, ub_den, ub_inf, ub_nan;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .word(a_q), .sign(ua_sign), .exp_unb(ua_exp), .frac(ua_frac),
    .is_zero(ua_zero), .is_denorm(ua_den), .is_inf(ua_inf), .is_nan(ua_nan)
  );

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .word(b_q), .sign(ub_sign), .exp_unb(ub_exp), .frac(ub_frac),
    .is_zero(ub_zero), .is_denorm(ub_den), .is_inf(ub_inf), .is_nan(ub_nan)
  );

  logic                  b_s_eff;
  logic                  is_special;
  logic                  special_invalid;
  logic [W-1:0]          special_z;
  logic signed [EW:0]    e_diff;
  logic                  a_gt_b_exp, b_gt_a_exp;
  logic                  a_ge_b;
  logic                  cancel;
  logic [SW-1:0]         mag_sum, mag_diff;
  logic                  round_up;
  logic [MAN_W+1:0]      rnd_m;
  logic [EXP_W-1:0]      exp_field_out;

  assign b_s_eff = ub_sign ^ op_q;

  always_comb begin
    is_special      = 1'b1;
    special_invalid = 1'b0;
    special_z       = '0;
    if (ua_nan || ub_nan) begin
      special_z       = QNAN;
      special_invalid = 1'b1;
    end else if (ua_inf && ub_inf && (ua_sign != b_s_eff)) begin
      special_z       = QNAN;
      special_invalid = 1'b1;
    end else if (ua_inf) begin
      special_z = {ua_sign, INF[W-2:0]};
    end else if (ub_inf) begin
      special_z = {b_s_eff, INF[W-2:0]};
    end else if (ua_zero && ub_zero) begin
      special_z = {ua_sign & b_s_eff, {(W-1){1'b0}}};
    end else if (ua_zero) begin
      special_z = {b_s_eff, b_q[W-2:0]};
    end else if (ub_zero) begin
      special_z = a_q;
    end else begin
      is_special = 1'b0;
    end
  end

  always_comb begin
    e_diff        = {a_e[EW-1], a_e} - {b_e[EW-1], b_e};
    a_gt_b_exp    = !e_diff[EW] && (e_diff != '0);
    b_gt_a_exp    = e_diff[EW];
    a_ge_b        = (a_m >= b_m);
    cancel        = (a_s != b_s) && (a_m == b_m);
    mag_sum       = {1'b0, a_m} + {1'b0, b_m};
    mag_diff      = a_ge_b ? {1'b0, a_m - b_m} : {1'b0, b_m - a_m};
    round_up      = z_m[2] & (z_m[1] | z_m[0] | z_m[3]);
    rnd_m         = {1'b0, z_m[MW-1:3]} + (MAN_W+2)'(round_up);
    exp_field_out = EXP_W'(z_e + $signed(EW'(BIAS)));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_GET_OPS:    if (bus.input_ack && bus.input_stb) state_nxt = ST_UNPACK;
      ST_UNPACK:     state_nxt = ST_SPECIAL;
      ST_SPECIAL:    state_nxt = is_special ? ST_PUT_Z : ST_ALIGN;
      ST_ALIGN:      if (a_e == b_e) state_nxt = ST_ADD;
      ST_ADD:        state_nxt = cancel ? ST_PUT_Z : ST_NORM_CARRY;
      ST_NORM_CARRY: state_nxt = ST_NORMALISE;
      ST_NORMALISE:  if (z_m[MW-1] || z_e <= E_MIN) state_nxt = ST_DENORM;
      ST_DENORM:     if (z_e >= E_MIN) state_nxt = ST_ROUND;
      ST_ROUND:      state_nxt = ST_PACK;
      ST_PACK:       state_nxt = ST_PUT_Z;
      ST_PUT_Z:      if (bus.output_z_stb && bus.output_z_ack) state_nxt = ST_GET_OPS;
      default:       state_nxt = ST_GET_OPS;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_GET_OPS;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.input_ack    <= 1'b0;
      bus.output_z_stb <= 1'b0;
      bus.output_z     <= '0;
      bus.output_flags <= '0;
      a_q <= '0;  b_q <= '0;  op_q <= 1'b0;
      a_s <= 1'b0; b_s <= 1'b0; z_s <= 1'b0;
      a_e <= '0;  b_e <= '0;  z_e <= '0;
      a_m <= '0;  b_m <= '0;  z_m <= '0;
    end else begin
      case (state)
        ST_GET_OPS: begin
          if (bus.input_ack && bus.input_stb) begin
            a_q           <= bus.input_a;
            b_q           <= bus.input_b;
            op_q          <= bus.input_op;
            bus.input_ack <= 1'b0;
          end else begin
            bus.input_ack <= 1'b1;
          end
        end
        ST_UNPACK: begin
          a_s <= ua_sign;
          a_e <= ua_exp;
          a_m <= {~(ua_zero | ua_den), ua_frac, 3'b000};
          b_s <= b_s_eff;
          b_e <= ub_exp;
          b_m <= {~(ub_zero | ub_den), ub_frac, 3'b000};
        end
        ST_SPECIAL: begin
          if (is_special) begin
            bus.output_z     <= special_z;
            bus.output_flags <= special_invalid ? FL_INVALID : '0;
            bus.output_z_stb <= 1'b1;
          end
        end
        ST_ALIGN: begin
          // Beyond MAN_W+3 positions every bit lands in sticky, so collapse at once.
          if (a_gt_b_exp) begin
            if (e_diff > ALIGN_LIM) begin
              b_m <= {{(MW-1){1'b0}}, |b_m};
              b_e <= a_e;
            end else begin
              b_m <= {1'b0, b_m[MW-1:2], b_m[1] | b_m[0]};
              b_e <= b_e + EW'(1);
            end
          end else if (b_gt_a_exp) begin
            if (e_diff < ALIGN_LIM_NEG) begin
              a_m <= {{(MW-1){1'b0}}, |a_m};
              a_e <= b_e;
            end else begin
              a_m <= {1'b0, a_m[MW-1:2], a_m[1] | a_m[0]};
              a_e <= a_e + EW'(1);
            end
          end
        end
        ST_ADD: begin
          z_e <= a_e;
          if (a_s == b_s) begin
            z_m <= mag_sum;
            z_s <= a_s;
          end else begin
            z_m <= mag_diff;
            z_s <= a_ge_b ? a_s : b_s;
          end
          if (cancel) begin
            bus.output_z     <= '0;
            bus.output_flags <= '0;
            bus.output_z_stb <= 1'b1;
          end
        end
        ST_NORM_CARRY: begin
          if (z_m[SW-1]) begin
            z_m <= {1'b0, z_m[SW-1:2], z_m[1] | z_m[0]};
            z_e <= z_e + EW'(1);
          end
        end
        ST_NORMALISE: begin
          if (!z_m[MW-1] && z_e > E_MIN) begin
            z_m <= {z_m[SW-2:0], 1'b0};
            z_e <= z_e - EW'(1);
          end
        end
        ST_DENORM: begin
          if (z_e < E_MIN) begin
            z_m <= {1'b0, z_m[SW-1:2], z_m[1] | z_m[0]};
            z_e <= z_e + EW'(1);
          end
        end
        ST_ROUND: begin
          bus.output_flags <= (|z_m[2:0]) ? FL_INEXACT : '0;
          if (rnd_m[MAN_W+1]) begin
            z_m <= {1'b0, rnd_m[MAN_W+1:1], 3'b000};
            z_e <= z_e + EW'(1);
          end else begin
            z_m <= {1'b0, rnd_m[MAN_W:0], 3'b000};
          end
        end
        ST_PACK: begin
          bus.output_z_stb <= 1'b1;
          if (z_e > E_MAX) begin
            bus.output_z     <= {z_s, INF[W-2:0]};
            bus.output_flags <= FL_OVF_INX;
          end else if (z_e == E_MIN && !z_m[MW-1]) begin
            bus.output_z <= {z_s, {EXP_W{1'b0}}, z_m[MW-2:3]};
          end else begin
            bus.output_z <= {z_s, exp_field_out, z_m[MW-2:3]};
          end
        end
        ST_PUT_Z: begin
          if (bus.output_z_stb && bus.output_z_ack) bus.output_z_stb <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_param.sv
// tb/tb_fp_addsub_param.sv - directed-vector bench for fp_addsub_param in single and half precision
module tb_fp_addsub_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fp_addsub_param_if #(.EXP_W(8), .MAN_W(23)) bus32 ();
  fp_addsub_param_if #(.EXP_W(5), .MAN_W(10)) bus16 ();

  fp_addsub_param #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  fp_addsub_param #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic in_ack(input bit half);
    return half ? bus16.input_ack : bus32.input_ack;
  endfunction

  function automatic logic out_stb(input bit half);
    return half ? bus16.output_z_stb : bus32.output_z_stb;
  endfunction

  function automatic logic [31:0] out_z(input bit half);
    return half ? {16'h0000, bus16.output_z} : bus32.output_z;
  endfunction

  function automatic logic [2:0] out_flags(input bit half);
    return half ? bus16.output_flags : bus32.output_flags;
  endfunction

  task automatic set_ops(input bit half, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic stb);
    if (half) begin
      bus16.input_a = a[15:0]; bus16.input_b = b[15:0];
      bus16.input_op = op;     bus16.input_stb = stb;
    end else begin
      bus32.input_a = a;  bus32.input_b = b;
      bus32.input_op = op; bus32.input_stb = stb;
    end
  endtask

  task automatic set_zack(input bit half, input logic v);
    if (half) bus16.output_z_ack = v;
    else      bus32.output_z_ack = v;
  endtask

  // Presents one operand pair and waits for the transfer, leaving stb low afterwards.
  task automatic send(input bit half, input logic [31:0] a, input logic [31:0] b,
                      input logic op, input string tag);
    int n;
    @(negedge clk);
    set_ops(half, a, b, op, 1'b1);
    n = 0;
    while (!in_ack(half) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, 64'(in_ack(half)), 64'd1);
    @(negedge clk);
    set_ops(half, a, b, op, 1'b0);
  endtask

  task automatic wait_result(input bit half, input string tag, output bit seen);
    int n;
    n = 0;
    while (!out_stb(half) && n < 300) begin
      @(negedge clk);
      n++;
    end
    seen = out_stb(half);
    check({tag, "_stb"}, 64'(seen), 64'd1);
  endtask

  task automatic take_result(input bit half);
    set_zack(half, 1'b1);
    @(negedge clk);
    set_zack(half, 1'b0);
  endtask

  task automatic do_op(input bit half, input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic [31:0] want_z, input logic [2:0] want_f,
                       input string tag);
    bit seen;
    send(half, a, b, op, tag);
    wait_result(half, tag, seen);
    if (seen) begin
      check({tag, "_z"}, 64'(out_z(half)), 64'(want_z));
      check({tag, "_flags"}, 64'(out_flags(half)), 64'(want_f));
      take_result(half);
    end
  endtask

  initial begin
    bit seen;
    int stray;
    set_ops(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_ops(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    set_zack(1'b0, 1'b0);
    set_zack(1'b1, 1'b0);

    repeat (3) @(negedge clk);
    check("rst_ack", 64'(bus32.input_ack), 64'd0);
    check("rst_stb", 64'(bus32.output_z_stb), 64'd0);
    check("rst_z", 64'(bus32.output_z), 64'd0);
    check("rst_flags", 64'(bus32.output_flags), 64'd0);
    check("rst_stb16", 64'(bus16.output_z_stb), 64'd0);
    rst = 1'b1;

    do_op(1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, "one_plus_two");
    do_op(1'b0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, "exact_cancel");
    do_op(1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, "negzero_sum");
    do_op(1'b0, 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100, "inf_minus_inf");
    do_op(1'b0, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100, "inf_sub_inf");
    do_op(1'b0, 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100, "nan_in");
    do_op(1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011, "overflow");
    do_op(1'b0, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000, "denorm_sum");
    do_op(1'b0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, "tie_even");
    do_op(1'b0, 32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b001, "round_up");
    do_op(1'b0, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, "three_minus_one");
    do_op(1'b0, 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000, "neg_result");
    do_op(1'b0, 32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 3'b000, "zero_minus_b");

    do_op(1'b1, 32'h3C00, 32'h3C00, 1'b0, 32'h4000, 3'b000, "h_one_plus_one");
    do_op(1'b1, 32'h4000, 32'h3C00, 1'b1, 32'h3C00, 3'b000, "h_two_minus_one");
    do_op(1'b1, 32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 3'b011, "h_overflow");
    do_op(1'b1, 32'h7C01, 32'h3C00, 1'b0, 32'h7E00, 3'b100, "h_nan_in");

    // Result must stay put while the consumer stalls.
    send(1'b0, 32'h3F800000, 32'h40000000, 1'b0, "hold");
    wait_result(1'b0, "hold", seen);
    if (seen) begin
      repeat (10) begin
        @(negedge clk);
        check("hold_stb", 64'(bus32.output_z_stb), 64'd1);
        check("hold_z", 64'(bus32.output_z), 64'h40400000);
        check("hold_flags", 64'(bus32.output_flags), 64'd0);
      end
      take_result(1'b0);
    end

    // Reset in the middle of a long alignment abandons the operation.
    send(1'b0, 32'h3F800000, 32'h34000000, 1'b0, "abort");
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_ack", 64'(bus32.input_ack), 64'd0);
    check("abort_stb", 64'(bus32.output_z_stb), 64'd0);
    check("abort_z", 64'(bus32.output_z), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    stray = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus32.output_z_stb) stray++;
    end
    check("abort_no_result", 64'(stray), 64'd0);

    do_op(1'b0, 32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, 3'b000, "after_abort");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
